// File: rtl/mux_reg_nx1_if.sv
// Handshake/bus bundle for mux_reg_nx1.
// sel_load exists only when MUX_SEL_LATCH_EN is defined.
interface mux_reg_nx1_if #(
    parameter int WIDTH  = 3,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
`ifdef MUX_SEL_LATCH_EN
    logic                    sel_load;
`endif

    modport master (
`ifdef MUX_SEL_LATCH_EN
        output sel_load,
`endif
        output in_bus,
        output sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  sel_err
    );

    modport slave (
`ifdef MUX_SEL_LATCH_EN
        input  sel_load,
`endif
        input  in_bus,
        input  sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output sel_err
    );
endinterface

// File: rtl/mux_reg_nx1.sv
// N:1 W-bit selector with a one-entry registered valid/ready output stage.
// Define MUX_SEL_LATCH_EN to capture from a held select register (sel_q).
module mux_reg_nx1 #(
    parameter int WIDTH  = 3,
    parameter int NUM_IN = 4
) (
    input logic           clk,
    input logic           reset,
    mux_reg_nx1_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] data_q;
    logic             err_q;
    logic [SEL_W-1:0] sel_eff;
    logic [WIDTH-1:0] mux_word;
    logic             sel_oor;
    logic             capture;

`ifdef MUX_SEL_LATCH_EN
    logic [SEL_W-1:0] sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= '0;
        end else if (bus.sel_load) begin
            sel_q <= bus.sel;
        end
    end

    // A load in the capture cycle bypasses the register.
    assign sel_eff = bus.sel_load ? bus.sel : sel_q;
`else
    assign sel_eff = bus.sel;
`endif

    assign sel_oor = int'(sel_eff) >= NUM_IN;

    always_comb begin
        mux_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_eff == SEL_W'(k)) begin
                mux_word = bus.in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.in_ready  = !bus.out_valid || bus.out_ready;
    assign capture       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (capture) begin
            state  <= FULL;
            data_q <= mux_word;
            err_q  <= sel_oor;
        end else if (state == FULL && bus.out_ready) begin
            state  <= EMPTY;
        end
    end

    assign bus.out_data = data_q;
    assign bus.sel_err  = err_q;
endmodule

// File: tb/tb_mux_reg_nx1.sv
// Directed bench for mux_reg_nx1: a NUM_IN=4 and a NUM_IN=3 instance.
// Latched-select cases run only when MUX_SEL_LATCH_EN is defined.
module tb_mux_reg_nx1;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mux_reg_nx1_if #(.WIDTH(3), .NUM_IN(4)) a_if ();
    mux_reg_nx1_if #(.WIDTH(3), .NUM_IN(3)) b_if ();

    mux_reg_nx1 #(.WIDTH(3), .NUM_IN(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    mux_reg_nx1 #(.WIDTH(3), .NUM_IN(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp3 [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        exp3  = '{3'd1, 3'd2, 3'd5, 3'd7};

        reset        = 1'b1;
        a_if.in_bus  = {3'd7, 3'd5, 3'd2, 3'd1};
        a_if.sel     = '0;
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b0;
        b_if.in_bus  = {3'd6, 3'd4, 3'd3};
        b_if.sel     = '0;
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 1'b0;
`ifdef MUX_SEL_LATCH_EN
        // Bypass path keeps the live-sel cases meaningful in this build.
        a_if.sel_load = 1'b1;
        b_if.sel_load = 1'b1;
`endif
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_data",  32'(a_if.out_data),  32'd0);
        check("rst_err",   32'(a_if.sel_err),   32'd0);
        check("rst_ready", 32'(a_if.in_ready),  32'd1);

        // Case 1: single capture
        a_if.sel = 2'd2;
        a_if.in_valid  = 1'b1;
        a_if.out_ready = 1'b1;
        tick();
        a_if.in_valid = 1'b0;
        check("c1_valid", 32'(a_if.out_valid), 32'd1);
        check("c1_data",  32'(a_if.out_data),  32'd5);
        check("c1_err",   32'(a_if.sel_err),   32'd0);
        tick();
        check("c1_drain_valid", 32'(a_if.out_valid), 32'd0);
        check("c1_drain_hold",  32'(a_if.out_data),  32'd5);

        // Case 2: stall with changing inputs
        a_if.sel = 2'd3;
        a_if.in_valid  = 1'b1;
        a_if.out_ready = 1'b0;
        tick();
        check("c2_fill", 32'(a_if.out_data), 32'd7);
        a_if.sel    = 2'd0;
        a_if.in_bus = {3'd0, 3'd3, 3'd6, 3'd4};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("c2_data",  32'(a_if.out_data),  32'd7);
            check("c2_valid", 32'(a_if.out_valid), 32'd1);
            check("c2_ready", 32'(a_if.in_ready),  32'd0);
        end
        a_if.in_bus = {3'd7, 3'd5, 3'd2, 3'd1};
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        tick();
        check("c2_drain", 32'(a_if.out_valid), 32'd0);

        // Case 3: back-to-back, no bubbles
        a_if.in_valid  = 1'b1;
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.sel = 2'(i);
            tick();
            check("c3_data",  32'(a_if.out_data),  32'(exp3[i]));
            check("c3_valid", 32'(a_if.out_valid), 32'd1);
        end
        a_if.in_valid = 1'b0;
        tick();
        check("c3_empty", 32'(a_if.out_valid), 32'd0);

        // Case 4: illegal select on NUM_IN=3
        b_if.sel = 2'd3;
        b_if.in_valid  = 1'b1;
        b_if.out_ready = 1'b1;
        tick();
        b_if.in_valid = 1'b0;
        check("c4_data",  32'(b_if.out_data),  32'd0);
        check("c4_err",   32'(b_if.sel_err),   32'd1);
        check("c4_valid", 32'(b_if.out_valid), 32'd1);
        tick();
        check("c4_drain", 32'(b_if.out_valid), 32'd0);
        check("c4_hold",  32'(b_if.sel_err),   32'd1);
        b_if.sel = 2'd1;
        b_if.in_valid = 1'b1;
        tick();
        b_if.in_valid = 1'b0;
        check("c4_legal_data", 32'(b_if.out_data), 32'd4);
        check("c4_legal_err",  32'(b_if.sel_err),  32'd0);

        // Case 5: reset while full and stalled
        a_if.sel = 2'd1;
        a_if.in_valid  = 1'b1;
        a_if.out_ready = 1'b0;
        tick();
        check("c5_fill", 32'(a_if.out_data), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_if.in_valid = 1'b0;
        #1;
        check("c5_valid", 32'(a_if.out_valid), 32'd0);
        check("c5_data",  32'(a_if.out_data),  32'd0);
        check("c5_err",   32'(a_if.sel_err),   32'd0);
        check("c5_ready", 32'(a_if.in_ready),  32'd1);

`ifdef MUX_SEL_LATCH_EN
        // Case 6: latched select
        a_if.out_ready = 1'b1;
        a_if.sel_load  = 1'b1;
        a_if.sel = 2'd3;
        tick();
        a_if.sel_load = 1'b0;
        a_if.sel = 2'd0;
        a_if.in_valid = 1'b1;
        tick();
        check("c6_latched", 32'(a_if.out_data), 32'd7);
        a_if.sel_load = 1'b1;
        a_if.sel = 2'd1;
        tick();
        check("c6_bypass", 32'(a_if.out_data), 32'd2);
        a_if.sel_load = 1'b0;
        a_if.sel = 2'd0;
        tick();
        check("c6_keep", 32'(a_if.out_data), 32'd2);
        a_if.in_valid = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
